// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and sizes for the out-of-order core's reorder buffer.
//   ROB_DEPTH / ROB_IDX_W : number of ROB entries and width of an entry index
//   ROB_CNT_W             : occupancy counter width (must hold ROB_DEPTH)
//   PHY_W                 : physical register tag width
//   rob_entry_t           : one ROB slot (status bits plus retirement payload)
//   rob_ptr_inc()         : circular pointer increment (wraps 15 -> 0)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int ROB_CNT_W = 5;
  localparam int PHY_W     = 8;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic             mispredict;
    logic             has_rd;
    logic             is_branch;
    logic [PHY_W-1:0] rd_phy;
    logic [PHY_W-1:0] old_phy;
    logic [31:0]      pc;
    logic [31:0]      target;
  } rob_entry_t;

  // Depth is a power of two, so natural overflow of the index gives the wrap.
  function automatic logic [ROB_IDX_W-1:0] rob_ptr_inc(input logic [ROB_IDX_W-1:0] p);
    return ROB_IDX_W'(p + 1'b1);
  endfunction

endpackage

// File: rtl/rob_perf_counters.sv
// -----------------------------------------------------------------------------
// rob_perf_counters
// Free-running retirement statistics for the reorder buffer. Only built when
// ROB_PERF_CNT_EN is defined; both counters wrap and clear on reset.
//   clk, rst (async, active-low)
//   i_commit        : one retirement this cycle
//   i_flush         : one mispredict flush this cycle
//   o_perf_commits  : number of retired instructions
//   o_perf_flushes  : number of flushes
// -----------------------------------------------------------------------------
`ifdef ROB_PERF_CNT_EN
module rob_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_commit,
  input  logic        i_flush,
  output logic [31:0] o_perf_commits,
  output logic [31:0] o_perf_flushes
);

  logic [31:0] r_commits;
  logic [31:0] r_flushes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_commits <= '0;
      r_flushes <= '0;
    end else begin
      if (i_commit) r_commits <= r_commits + 32'd1;
      if (i_flush)  r_flushes <= r_flushes + 32'd1;
    end
  end

  assign o_perf_commits = r_commits;
  assign o_perf_flushes = r_flushes;

endmodule
`endif

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// 16-entry circular reorder buffer: allocates entries in program order,
// collects out-of-order completions from four execution ports and retires the
// head entry in order. A retiring branch flagged as mispredicted flushes the
// whole buffer.
//
// Optional build macro: ROB_PERF_CNT_EN adds perf_commits / perf_flushes.
//
// Ports
//   clk, rst                  : clock, async active-low reset
//   alloc_valid/alloc_ready   : dispatch handshake (one entry per cycle)
//   alloc_rd_phy/old_phy      : new destination tag / previous RAT mapping
//   alloc_has_rd/is_branch/pc : instruction attributes
//   alloc_idx                 : ROB index handed to the allocating instruction
//   {alu,mul,div,load}_done/_idx : completion reports
//   alu_mispredict/alu_target : branch outcome, qualified by alu_done
//   commit_valid/has_rd/rd_phy/old_phy : in-order retirement
//   rob_flush/flush_pc        : mispredict recovery
// -----------------------------------------------------------------------------
module reorder_buffer
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [PHY_W-1:0]     alloc_rd_phy,
  input  logic [PHY_W-1:0]     alloc_old_phy,
  input  logic                 alloc_has_rd,
  input  logic                 alloc_is_branch,
  input  logic [31:0]          alloc_pc,
  output logic [ROB_IDX_W-1:0] alloc_idx,
  input  logic                 alu_done,
  input  logic [ROB_IDX_W-1:0] alu_idx,
  input  logic                 mul_done,
  input  logic [ROB_IDX_W-1:0] mul_idx,
  input  logic                 div_done,
  input  logic [ROB_IDX_W-1:0] div_idx,
  input  logic                 load_done,
  input  logic [ROB_IDX_W-1:0] load_idx,
  input  logic                 alu_mispredict,
  input  logic [31:0]          alu_target,
  output logic                 commit_valid,
  output logic                 commit_has_rd,
  output logic [PHY_W-1:0]     commit_rd_phy,
  output logic [PHY_W-1:0]     commit_old_phy,
  output logic                 rob_flush,
  output logic [31:0]          flush_pc
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_commits,
  output logic [31:0]          perf_flushes
`endif
);

  // Status bits live in reset flops; the payload array is plain storage that
  // is only meaningful while the matching valid bit is set.
  logic [ROB_IDX_W-1:0] r_head;
  logic [ROB_IDX_W-1:0] r_tail;
  logic [ROB_CNT_W-1:0] r_count;
  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_misp;
  rob_entry_t           r_payload [ROB_DEPTH];

  logic                 w_alloc;
  logic                 w_commit;
  logic                 w_flush;
  rob_entry_t           w_head;
  rob_entry_t           w_new;
  logic [ROB_DEPTH-1:0] w_done_set;
  logic [ROB_DEPTH-1:0] w_valid_nxt;
  logic [ROB_DEPTH-1:0] w_done_nxt;
  logic [ROB_DEPTH-1:0] w_misp_nxt;
  logic [ROB_CNT_W-1:0] w_count_nxt;
  logic                 w_alu_hit;
  logic                 w_unused_attr;

  // Readiness comes from the registered count only, so a same-cycle commit
  // never opens a slot for a same-cycle allocation.
  assign alloc_ready = (r_count < ROB_CNT_W'(ROB_DEPTH));
  assign alloc_idx   = r_tail;
  assign w_alloc     = alloc_valid && alloc_ready && !w_flush;
  assign w_alu_hit   = alu_done && r_valid[alu_idx];

  always_comb begin
    w_head            = r_payload[r_head];
    w_head.valid      = r_valid[r_head];
    w_head.done       = r_done[r_head];
    w_head.mispredict = r_misp[r_head];
  end

  // done is registered, so an entry can retire no earlier than the cycle
  // after its completion edge.
  assign w_commit = w_head.valid && w_head.done;
  assign w_flush  = w_commit && w_head.mispredict;

  assign commit_valid   = w_commit;
  assign commit_has_rd  = w_commit && w_head.has_rd;
  assign commit_rd_phy  = w_commit ? w_head.rd_phy  : '0;
  assign commit_old_phy = w_commit ? w_head.old_phy : '0;
  assign rob_flush      = w_flush;
  assign flush_pc       = w_flush ? w_head.target : '0;

  // pc and is_branch are carried for debug/trace visibility only.
  assign w_unused_attr = ^{w_head.is_branch, w_head.pc};

  always_comb begin
    w_new           = '0;
    w_new.has_rd    = alloc_has_rd;
    w_new.is_branch = alloc_is_branch;
    w_new.rd_phy    = alloc_rd_phy;
    w_new.old_phy   = alloc_old_phy;
    w_new.pc        = alloc_pc;
  end

  // Next-state of the status vectors. Ordering matters: completions first,
  // then the head clear, then the new tail entry, and a flush overrides all.
  always_comb begin
    w_done_set = '0;
    if (alu_done)  w_done_set[alu_idx]  = 1'b1;
    if (mul_done)  w_done_set[mul_idx]  = 1'b1;
    if (div_done)  w_done_set[div_idx]  = 1'b1;
    if (load_done) w_done_set[load_idx] = 1'b1;
    w_done_set = w_done_set & r_valid;

    w_valid_nxt = r_valid;
    w_done_nxt  = r_done | w_done_set;
    w_misp_nxt  = r_misp;
    if (w_alu_hit) w_misp_nxt[alu_idx] = alu_mispredict;

    if (w_commit) begin
      w_valid_nxt[r_head] = 1'b0;
      w_done_nxt[r_head]  = 1'b0;
      w_misp_nxt[r_head]  = 1'b0;
    end

    if (w_alloc) begin
      w_valid_nxt[r_tail] = 1'b1;
      w_done_nxt[r_tail]  = 1'b0;
      w_misp_nxt[r_tail]  = 1'b0;
    end

    if (w_flush) begin
      w_valid_nxt = '0;
      w_done_nxt  = '0;
      w_misp_nxt  = '0;
    end
  end

  always_comb begin
    case ({w_alloc, w_commit})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
      r_misp  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_misp  <= w_misp_nxt;
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_count <= w_count_nxt;
        if (w_commit) r_head <= rob_ptr_inc(r_head);
        if (w_alloc)  r_tail <= rob_ptr_inc(r_tail);
      end
    end
  end

  // Payload storage: written on allocation, branch target latched on ALU
  // completion. The tail slot is never valid while an allocation can happen,
  // so the two writes never collide on a live entry.
  always_ff @(posedge clk) begin
    if (w_alloc)   r_payload[r_tail]         <= w_new;
    if (w_alu_hit) r_payload[alu_idx].target <= alu_target;
  end

`ifdef ROB_PERF_CNT_EN
  rob_perf_counters u_perf (
    .clk            (clk),
    .rst            (rst),
    .i_commit       (w_commit),
    .i_flush        (w_flush),
    .o_perf_commits (perf_commits),
    .o_perf_flushes (perf_flushes)
  );
`endif

endmodule
